reorder_buffer: RTL and testbench

- Circular reorder buffer (ROB) of the Tomasulo-style RV32I core.
- Receives allocation requests from the Decoder and returns the tag of the next free slot.
- Answers the Decoder's operand tag lookups, captures execution results from the common data bus (CDB), and retires entries in program order to the Regfile.

---
 rtl/reorder_buffer_pkg.sv | 30 +++
 rtl/rob_lookup_port.sv | 42 ++++
 rtl/reorder_buffer.sv | 175 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: entry classes, the tagFree marker,
// and the bit layout of the packed robData allocation word.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH_DEF = 8;
    localparam int TAG_W_DEF     = 4;
    localparam int DATA_W_DEF    = 32;
    localparam int REG_W_DEF     = 5;

    // A tag equal to the depth means "no producer": the operand is already in the Regfile.
    localparam logic [TAG_W_DEF-1:0] tagFree = TAG_W_DEF'(ROB_DEPTH_DEF);

    localparam int robWidth = 2 + 2*DATA_W_DEF + 1;

    localparam int robClassLsb = 0;
    localparam int robClassMsb = 1;
    localparam int robDestLsb  = 2;
    localparam int robDestMsb  = DATA_W_DEF + 1;
    localparam int robValueLsb = DATA_W_DEF + 2;
    localparam int robValueMsb = 2*DATA_W_DEF + 1;
    localparam int robReadyBit = 2*DATA_W_DEF + 2;

    typedef enum logic [1:0] {
        robClassNormal = 2'd0,
        robClassStore  = 2'd1,
        robClassBranch = 2'd2,
        robClassJump   = 2'd3
    } rob_class_e;

endpackage

// File: rtl/rob_lookup_port.sv
// Combinational operand lookup into the reorder buffer, with a same-cycle
// bypass from the common data bus so a just-broadcast result is seen at once.
module rob_lookup_port
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic [TAG_W-1:0]            tag,
    input  logic                        cdb_enable,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [DATA_W-1:0]           cdb_data,
    input  logic [ROB_DEPTH-1:0]        entry_ready,
    input  logic [ROB_DEPTH*DATA_W-1:0] entry_value,
    output logic                        ready,
    output logic [DATA_W-1:0]           data
);

    localparam int PTR_W = $clog2(ROB_DEPTH);
    localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(ROB_DEPTH);

    logic [PTR_W-1:0] idx;

    assign idx = tag[PTR_W-1:0];

    always_comb begin
        ready = 1'b0;
        data  = '0;
        if (tag == TAG_FREE) begin
            ready = 1'b1;
            data  = '0;
        end else if (cdb_enable && (cdb_tag == tag)) begin
            ready = 1'b1;
            data  = cdb_data;
        end else begin
            ready = entry_ready[idx];
            data  = entry_value[idx*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates in order, captures CDB results, retires in order.
// Optional build macro ROB_FLUSH_EN adds a robFlush input that empties the buffer.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_W     = REG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  robEnable,
    input  logic [2*DATA_W+2:0]   robData,
    output logic [TAG_W-1:0]      ROBtail,
    output logic                  robFull,
    input  logic [TAG_W-1:0]      tagCheck1,
    input  logic [TAG_W-1:0]      tagCheck2,
    output logic                  tag1Ready,
    output logic                  tag2Ready,
    output logic [DATA_W-1:0]     robData1,
    output logic [DATA_W-1:0]     robData2,
    input  logic                  cdbEnable,
    input  logic [TAG_W-1:0]      cdbTag,
    input  logic [DATA_W-1:0]     cdbData,
`ifdef ROB_FLUSH_EN
    input  logic                  robFlush,
`endif
    output logic                  commitEnable,
    output logic [REG_W-1:0]      commitAddr,
    output logic [TAG_W-1:0]      commitTag,
    output logic [DATA_W-1:0]     commitData
);

    localparam int PTR_W = $clog2(ROB_DEPTH);
    localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0]        valid_q;
    logic [ROB_DEPTH-1:0]        ready_q;
    logic [DATA_W-1:0]           value_q [ROB_DEPTH];
    logic [REG_W-1:0]            dest_q  [ROB_DEPTH];
    rob_class_e                  class_q [ROB_DEPTH];
    logic [ROB_DEPTH*DATA_W-1:0] value_flat;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             flush;
    logic             do_alloc;
    logic             do_commit;
    logic             wb_hit;
    logic [PTR_W-1:0] wb_idx;

    logic             in_ready;
    logic [DATA_W-1:0] in_value;
    logic [REG_W-1:0] in_dest;
    rob_class_e       in_class;
    logic             unused_dest_hi;

`ifdef ROB_FLUSH_EN
    assign flush = robFlush;
`else
    assign flush = 1'b0;
`endif

    assign in_ready       = robData[2*DATA_W+2];
    assign in_value       = robData[2*DATA_W+1:DATA_W+2];
    assign in_dest        = robData[REG_W+1:2];
    assign in_class       = rob_class_e'(robData[1:0]);
    assign unused_dest_hi = ^robData[DATA_W+1:REG_W+2];

    assign robFull   = (count == (PTR_W+1)'(ROB_DEPTH));
    assign ROBtail   = TAG_W'(tail);
    assign do_alloc  = robEnable && !robFull;
    assign do_commit = valid_q[head] && ready_q[head];
    assign wb_idx    = cdbTag[PTR_W-1:0];

    // A broadcast aimed at the entry retiring this cycle is dropped so the slot stays clean.
    assign wb_hit = cdbEnable && (cdbTag != TAG_FREE) && valid_q[wb_idx]
                    && !(do_commit && (wb_idx == head));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            ready_q      <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commitEnable <= 1'b0;
            commitAddr   <= '0;
            commitTag    <= '0;
            commitData   <= '0;
        end else if (flush) begin
            valid_q      <= '0;
            ready_q      <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commitEnable <= 1'b0;
        end else begin
            commitEnable <= 1'b0;
            if (do_commit) begin
                valid_q[head] <= 1'b0;
                ready_q[head] <= 1'b0;
                head          <= head + 1'b1;
                commitEnable  <= (class_q[head] == robClassNormal) && (dest_q[head] != '0);
                commitAddr    <= dest_q[head];
                commitTag     <= TAG_W'(head);
                commitData    <= value_q[head];
            end
            if (wb_hit) begin
                ready_q[wb_idx] <= 1'b1;
            end
            if (do_alloc) begin
                valid_q[tail] <= 1'b1;
                ready_q[tail] <= in_ready;
                tail          <= tail + 1'b1;
            end
            count <= count + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(do_commit);
        end
    end

    // Payload carries no reset; the valid/ready bits above decide whether it means anything.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (wb_hit) begin
                value_q[wb_idx] <= cdbData;
            end
            if (do_alloc) begin
                value_q[tail] <= in_value;
                dest_q[tail]  <= in_dest;
                class_q[tail] <= in_class;
            end
        end
    end

    always_comb begin
        value_flat = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            value_flat[i*DATA_W +: DATA_W] = value_q[i];
        end
    end

    rob_lookup_port #(
        .ROB_DEPTH(ROB_DEPTH),
        .TAG_W    (TAG_W),
        .DATA_W   (DATA_W)
    ) u_lookup1 (
        .tag        (tagCheck1),
        .cdb_enable (cdbEnable),
        .cdb_tag    (cdbTag),
        .cdb_data   (cdbData),
        .entry_ready(ready_q),
        .entry_value(value_flat),
        .ready      (tag1Ready),
        .data       (robData1)
    );

    rob_lookup_port #(
        .ROB_DEPTH(ROB_DEPTH),
        .TAG_W    (TAG_W),
        .DATA_W   (DATA_W)
    ) u_lookup2 (
        .tag        (tagCheck2),
        .cdb_enable (cdbEnable),
        .cdb_tag    (cdbTag),
        .cdb_data   (cdbData),
        .entry_ready(ready_q),
        .entry_value(value_flat),
        .ready      (tag2Ready),
        .data       (robData2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; retirements are checked against a queue of
// expected commits pushed when the completing stimulus is driven.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        robEnable;
    logic [66:0] robData;
    logic [3:0]  ROBtail;
    logic        robFull;
    logic [3:0]  tagCheck1;
    logic [3:0]  tagCheck2;
    logic        tag1Ready;
    logic        tag2Ready;
    logic [31:0] robData1;
    logic [31:0] robData2;
    logic        cdbEnable;
    logic [3:0]  cdbTag;
    logic [31:0] cdbData;
`ifdef ROB_FLUSH_EN
    logic        robFlush;
`endif
    logic        commitEnable;
    logic [4:0]  commitAddr;
    logic [3:0]  commitTag;
    logic [31:0] commitData;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t expq[$];

    reorder_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .robEnable   (robEnable),
        .robData     (robData),
        .ROBtail     (ROBtail),
        .robFull     (robFull),
        .tagCheck1   (tagCheck1),
        .tagCheck2   (tagCheck2),
        .tag1Ready   (tag1Ready),
        .tag2Ready   (tag2Ready),
        .robData1    (robData1),
        .robData2    (robData2),
        .cdbEnable   (cdbEnable),
        .cdbTag      (cdbTag),
        .cdbData     (cdbData),
`ifdef ROB_FLUSH_EN
        .robFlush    (robFlush),
`endif
        .commitEnable(commitEnable),
        .commitAddr  (commitAddr),
        .commitTag   (commitTag),
        .commitData  (commitData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [66:0] pack(input logic rdy, input logic [31:0] val,
                                         input logic [31:0] dest, input logic [1:0] cls);
        return {rdy, val, dest, cls};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [66:0] data, input logic cen,
                                 input logic [3:0] ctag, input logic [31:0] cdata);
        robEnable = en;
        robData   = data;
        cdbEnable = cen;
        cdbTag    = ctag;
        cdbData   = cdata;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectCommit(input logic [4:0] addr, input logic [3:0] tag,
                                input logic [31:0] data);
        exp_t e;
        e.addr = addr;
        e.tag  = tag;
        e.data = data;
        expq.push_back(e);
    endtask

    // Every commitEnable pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #2;
        if (commitEnable === 1'b1) begin
            checkOutput("commit_expected", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                checkOutput("commit_addr", 32'(commitAddr), 32'(e.addr));
                checkOutput("commit_tag", 32'(commitTag), 32'(e.tag));
                checkOutput("commit_data", commitData, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        tagCheck1 = tagFree;
        tagCheck2 = tagFree;
`ifdef ROB_FLUSH_EN
        robFlush = 1'b0;
`endif
        #12;
        checkOutput("reset_tail", 32'(ROBtail), 32'd0);
        checkOutput("reset_full", 32'(robFull), 32'd0);
        checkOutput("reset_commit_en", 32'(commitEnable), 32'd0);
        checkOutput("reset_commit_addr", 32'(commitAddr), 32'd0);
        checkOutput("reset_commit_tag", 32'(commitTag), 32'd0);
        checkOutput("reset_commit_data", commitData, 32'd0);
        rst = 1'b0;
        #1;

        // Three in-flight allocations, none ready.
        for (int i = 0; i < 3; i++) begin
            checkOutput("alloc_tail", 32'(ROBtail), 32'(i));
            applyStimulus(1'b1, pack(1'b0, 32'd0, 32'(i + 1), robClassNormal), 1'b0, 4'd0, 32'd0);
            waitCycles(1);
        end
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        checkOutput("alloc3_tail", 32'(ROBtail), 32'd3);
        checkOutput("alloc3_full", 32'(robFull), 32'd0);

        // Out-of-order completion, in-order retirement.
        applyStimulus(1'b0, '0, 1'b1, 4'd1, 32'hAA);
        waitCycles(1);
        expectCommit(5'd1, 4'd0, 32'h55);
        expectCommit(5'd2, 4'd1, 32'hAA);
        applyStimulus(1'b0, '0, 1'b1, 4'd0, 32'h55);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        checkOutput("no_commit_same_cycle", 32'(commitEnable), 32'd0);
        waitCycles(1);
        checkOutput("commit0_en", 32'(commitEnable), 32'd1);
        checkOutput("commit0_tag", 32'(commitTag), 32'd0);
        checkOutput("commit0_data", commitData, 32'h55);
        waitCycles(1);
        checkOutput("commit1_en", 32'(commitEnable), 32'd1);
        checkOutput("commit1_tag", 32'(commitTag), 32'd1);
        checkOutput("commit1_data", commitData, 32'hAA);

        // Lookup: entry 2 pending, then CDB bypass and tagFree.
        tagCheck1 = 4'd2;
        #1;
        checkOutput("lookup_pending_ready", 32'(tag1Ready), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 4'd2, 32'h1234);
        tagCheck2 = tagFree;
        expectCommit(5'd3, 4'd2, 32'h1234);
        #1;
        checkOutput("bypass_ready", 32'(tag1Ready), 32'd1);
        checkOutput("bypass_data", robData1, 32'h1234);
        checkOutput("tagfree_ready", 32'(tag2Ready), 32'd1);
        checkOutput("tagfree_data", robData2, 32'd0);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        #1;
        checkOutput("entry_ready", 32'(tag1Ready), 32'd1);
        checkOutput("entry_data", robData1, 32'h1234);
        waitCycles(1);
        tagCheck1 = tagFree;

        // Writeback to an empty slot must be dropped.
        applyStimulus(1'b0, '0, 1'b1, 4'd7, 32'hDEAD);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        tagCheck1 = 4'd7;
        #1;
        checkOutput("wb_invalid_ignored", 32'(tag1Ready), 32'd0);
        tagCheck1 = tagFree;

        // Fill all eight slots starting from tag 3, then overflow attempt.
        for (int i = 0; i < 8; i++) begin
            checkOutput("fill_tail", 32'(ROBtail), 32'((3 + i) % 8));
            applyStimulus(1'b1, pack(1'b0, 32'd0, 32'd5, robClassNormal), 1'b0, 4'd0, 32'd0);
            waitCycles(1);
        end
        checkOutput("full_flag", 32'(robFull), 32'd1);
        checkOutput("full_tail", 32'(ROBtail), 32'd3);
        waitCycles(1);
        checkOutput("overflow_tail_hold", 32'(ROBtail), 32'd3);
        checkOutput("overflow_full_hold", 32'(robFull), 32'd1);
        expectCommit(5'd5, 4'd3, 32'h77);
        applyStimulus(1'b1, pack(1'b1, 32'h99, 32'd6, robClassNormal), 1'b1, 4'd3, 32'h77);
        waitCycles(1);
        checkOutput("full_before_retire", 32'(robFull), 32'd1);
        applyStimulus(1'b1, pack(1'b1, 32'h99, 32'd6, robClassNormal), 1'b0, 4'd0, 32'd0);
        waitCycles(1);
        checkOutput("full_commit_no_alloc_full", 32'(robFull), 32'd0);
        checkOutput("full_commit_no_alloc_tail", 32'(ROBtail), 32'd3);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        checkOutput("wrap_alloc_full", 32'(robFull), 32'd1);
        checkOutput("wrap_alloc_tail", 32'(ROBtail), 32'd4);

        // Drain everything in order.
        for (int k = 0; k < 7; k++) begin
            expectCommit(5'd5, 4'((4 + k) % 8), 32'h100 + 32'(k));
            applyStimulus(1'b0, '0, 1'b1, 4'((4 + k) % 8), 32'h100 + 32'(k));
            waitCycles(1);
        end
        expectCommit(5'd6, 4'd3, 32'h99);
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        waitCycles(3);
        checkOutput("drain_tail", 32'(ROBtail), 32'd4);
        checkOutput("drain_full", 32'(robFull), 32'd0);
        checkOutput("drain_queue", 32'(expq.size()), 32'd0);

        // Silent retirements: dest 0, then a store class.
        applyStimulus(1'b1, pack(1'b1, 32'hCAFE, 32'd0, robClassNormal), 1'b0, 4'd0, 32'd0);
        waitCycles(1);
        applyStimulus(1'b1, pack(1'b1, 32'hBEEF, 32'd7, robClassStore), 1'b0, 4'd0, 32'd0);
        waitCycles(1);
        checkOutput("dest0_en", 32'(commitEnable), 32'd0);
        checkOutput("dest0_tag", 32'(commitTag), 32'd4);
        checkOutput("dest0_data", commitData, 32'hCAFE);
        expectCommit(5'd9, 4'd6, 32'h42);
        applyStimulus(1'b1, pack(1'b1, 32'h42, 32'd9, robClassNormal), 1'b0, 4'd0, 32'd0);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        checkOutput("store_en", 32'(commitEnable), 32'd0);
        checkOutput("store_tag", 32'(commitTag), 32'd5);
        checkOutput("store_data", commitData, 32'hBEEF);
        checkOutput("store_tail", 32'(ROBtail), 32'd7);
        waitCycles(2);

        // Asynchronous reset while a ready entry waits to retire.
        applyStimulus(1'b1, pack(1'b1, 32'h5A, 32'd3, robClassNormal), 1'b0, 4'd0, 32'd0);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_tail", 32'(ROBtail), 32'd0);
        checkOutput("midreset_full", 32'(robFull), 32'd0);
        checkOutput("midreset_commit_en", 32'(commitEnable), 32'd0);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2);
        checkOutput("postreset_commit_en", 32'(commitEnable), 32'd0);
        checkOutput("postreset_tail", 32'(ROBtail), 32'd0);

`ifdef ROB_FLUSH_EN
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pack(1'b0, 32'd0, 32'(i + 1), robClassNormal), 1'b0, 4'd0, 32'd0);
            waitCycles(1);
        end
        checkOutput("preflush_tail", 32'(ROBtail), 32'd4);
        applyStimulus(1'b1, pack(1'b1, 32'd1, 32'd1, robClassNormal), 1'b1, 4'd0, 32'd1);
        robFlush = 1'b1;
        waitCycles(1);
        robFlush = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        checkOutput("flush_tail", 32'(ROBtail), 32'd0);
        checkOutput("flush_full", 32'(robFull), 32'd0);
        checkOutput("flush_commit_en", 32'(commitEnable), 32'd0);
        waitCycles(2);
        checkOutput("postflush_commit_en", 32'(commitEnable), 32'd0);
        applyStimulus(1'b1, pack(1'b0, 32'd0, 32'd2, robClassNormal), 1'b0, 4'd0, 32'd0);
        waitCycles(1);
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 32'd0);
        checkOutput("postflush_alloc_tail", 32'(ROBtail), 32'd1);
`endif

        waitCycles(3);
        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
